// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment readback monitor.
//   - SEG7_0..SEG7_9, SEG7_BLANK : abcdefg patterns (bit6=a .. bit0=g), active-high
//   - BCD_BLANK / BCD_ERR        : reconstructed codes for blank and illegal patterns
//   - scan_state_e               : capture FSM states
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b1111110;
  localparam logic [6:0] SEG7_1     = 7'b0110000;
  localparam logic [6:0] SEG7_2     = 7'b1101101;
  localparam logic [6:0] SEG7_3     = 7'b1111001;
  localparam logic [6:0] SEG7_4     = 7'b0110011;
  localparam logic [6:0] SEG7_5     = 7'b1011011;
  localparam logic [6:0] SEG7_6     = 7'b1011111;
  localparam logic [6:0] SEG7_7     = 7'b1110000;
  localparam logic [6:0] SEG7_8     = 7'b1111111;
  localparam logic [6:0] SEG7_9     = 7'b1111011;
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  // WAIT   : strobe bus is not one-hot, nothing to look at
  // SETTLE : one digit selected, counting stable cycles
  // HELD   : this dwell has been captured, wait for the bus to move
  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational inverse of the BCD-to-7-segment encoder.
// Ports:
//   seg7 (in, 7)  abcdefg pattern, bit6=a .. bit0=g
//   code (out, 4) 0..9 for a digit, BCD_BLANK for all-off, BCD_ERR otherwise
//   err  (out, 1) pattern is neither a digit nor blank
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg7,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = BCD_ERR;
    err  = 1'b1;
    case (seg7)
      SEG7_0:     begin code = 4'd0;      err = 1'b0; end
      SEG7_1:     begin code = 4'd1;      err = 1'b0; end
      SEG7_2:     begin code = 4'd2;      err = 1'b0; end
      SEG7_3:     begin code = 4'd3;      err = 1'b0; end
      SEG7_4:     begin code = 4'd4;      err = 1'b0; end
      SEG7_5:     begin code = 4'd5;      err = 1'b0; end
      SEG7_6:     begin code = 4'd6;      err = 1'b0; end
      SEG7_7:     begin code = 4'd7;      err = 1'b0; end
      SEG7_8:     begin code = 4'd8;      err = 1'b0; end
      SEG7_9:     begin code = 4'd9;      err = 1'b0; end
      SEG7_BLANK: begin code = BCD_BLANK; err = 1'b0; end
      default:    begin code = BCD_ERR;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: monitors a multiplexed 7-segment bus and rebuilds the
// displayed BCD digits, one frame (all digits) at a time.
// Parameters:
//   NUM_DIGITS    number of multiplexed digits (strobe width)
//   STABLE_CYCLES unchanged cycles required before a pattern is captured (>=1)
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   seg7        abcdefg pattern, active-high
//   dig_sel     one-hot digit strobe, bit i = digit i
//   out_valid / out_ready  frame handshake; the frame moves on valid & ready.
//               While out_valid=1 and out_ready=0, bcd_out/err_out hold steady.
//   bcd_out     digit i at [4i+3:4i]
//   err_out     bit i = digit i was an illegal pattern
//   overrun     sticky, a completed frame was dropped because the last one
//               was still pending
// Optional feature (macro SEG7_ERR_CNT_EN):
//   err_cnt     8-bit saturating count of captures of illegal patterns
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg7,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    overrun
`ifdef SEG7_ERR_CNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  scan_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [6:0]              prev_seg;
  logic [NUM_DIGITS-1:0]   prev_sel;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] slot_bcd;
  logic [NUM_DIGITS-1:0]   slot_err;

  logic                    changed;
  logic                    sel_onehot;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_bits;
  logic                    frame_full;
  logic                    frame_load;
  logic [3:0]              dec_code;
  logic                    dec_err;

  seg7_to_bcd u_dec (
    .seg7 (seg7),
    .code (dec_code),
    .err  (dec_err)
  );

  assign changed    = (seg7 != prev_seg) || (dig_sel != prev_sel);
  assign sel_onehot = $onehot(dig_sel);
  assign cap_bits   = capture ? dig_sel : '0;
  assign frame_full = &mask;
  // A full frame is handed out if the output register is free or is being
  // emptied on this very edge; otherwise it is lost.
  assign frame_load = frame_full && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT;
      cnt      <= '0;
      prev_seg <= '0;
      prev_sel <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      prev_seg <= seg7;
      prev_sel <= dig_sel;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!sel_onehot) begin
      state_nxt = WAIT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        // Becoming one-hot is itself a change, so counting starts fresh.
        WAIT: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
        SETTLE: begin
          if (changed) begin
            cnt_nxt = '0;
          end else if (cnt == CNT_LAST) begin
            capture   = 1'b1;
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HELD: begin
          if (changed) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Slots always take the latest capture; a transfer on the same edge reads
  // the previous slot contents, and the new capture starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      slot_bcd <= '0;
      slot_err <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_bits[i]) begin
          slot_bcd[4*i +: 4] <= dec_code;
          slot_err[i]        <= dec_err;
        end
      end
      if (frame_full) begin
        mask <= cap_bits;
      end else begin
        mask <= mask | cap_bits;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bcd_out   <= '0;
      err_out   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (frame_load) begin
        out_valid <= 1'b1;
        bcd_out   <= slot_bcd;
        err_out   <= slot_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (frame_full && !frame_load) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SEG7_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (capture && dec_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scenarios plus randomized display traffic,
// checked every cycle against a run-length based reference model.
module tb_seg7_scan_decoder;

  localparam int ND = 2;
  localparam int SC = 4;

  localparam logic [6:0] PAT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // ---------------------------------------------------------------- clock/reset
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg7 = '0;
  logic [ND-1:0]   dig_sel = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   err_out;
  logic            overrun;
`ifdef SEG7_ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg7      (seg7),
    .dig_sel   (dig_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .err_out   (err_out),
    .overrun   (overrun)
`ifdef SEG7_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // A digit is captured when its strobe is one-hot and the bus sample has been
  // identical for exactly SC edges after the edge that first saw it.
  logic            m_valid, m_overrun;
  logic [4*ND-1:0] m_bcd, m_slot_bcd;
  logic [ND-1:0]   m_err, m_slot_err, m_mask;
  logic [6:0]      m_prev_seg;
  logic [ND-1:0]   m_prev_sel;
  int              m_run;
  int              m_errcnt;
  logic [5*ND-1:0] exp_q[$];

  function automatic void ref_decode(input logic [6:0] s, output logic [3:0] c, output logic e);
    c = 4'hE;
    e = 1'b1;
    if (s == 7'd0) begin
      c = 4'hF;
      e = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (PAT[k] == s) begin
        c = 4'(k);
        e = 1'b0;
      end
    end
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_overrun = 1'b0;
    m_bcd = '0; m_err = '0;
    m_slot_bcd = '0; m_slot_err = '0; m_mask = '0;
    m_prev_seg = '0; m_prev_sel = '0;
    m_run = 0; m_errcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_update();
    logic [3:0] mc;
    logic       me;
    if (m_mask == {ND{1'b1}}) begin
      if (!m_valid || out_ready) begin
        m_bcd   = m_slot_bcd;
        m_err   = m_slot_err;
        m_valid = 1'b1;
        exp_q.push_back({m_slot_err, m_slot_bcd});
      end else begin
        m_overrun = 1'b1;
      end
      m_mask = '0;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (seg7 == m_prev_seg && dig_sel == m_prev_sel) m_run++;
    else m_run = 1;
    m_prev_seg = seg7;
    m_prev_sel = dig_sel;
    if ($countones(dig_sel) == 1 && m_run == SC + 1) begin
      ref_decode(seg7, mc, me);
      for (int k = 0; k < ND; k++) begin
        if (dig_sel[k]) begin
          m_slot_bcd[4*k +: 4] = mc;
          m_slot_err[k]        = me;
          m_mask[k]            = 1'b1;
        end
      end
      if (me && m_errcnt < 255) m_errcnt++;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_overrun));
    check("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check("err_out", 32'(err_out), 32'(m_err));
`ifdef SEG7_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
  endtask

  // ---------------------------------------------------------------- driver tasks
  // Called at a falling edge: drive inputs, advance the model over the rising
  // edge, then compare at the next falling edge.
  task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input logic r);
    logic [5*ND-1:0] f;
    seg7 = s;
    dig_sel = d;
    out_ready = r;
    if (out_valid && r) begin
      if (exp_q.size() == 0) begin
        check("frame_queue_nonempty", 32'd0, 32'd1);
      end else begin
        f = exp_q.pop_front();
        check("accepted_frame", 32'({err_out, bcd_out}), 32'(f));
      end
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic show(input logic [ND-1:0] d, input logic [6:0] s, input int n, input logic r);
    for (int k = 0; k < n; k++) step(s, d, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg7 = '0;
    dig_sel = '0;
    model_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd_out", 32'(bcd_out), 32'd0);
    check("rst_err_out", 32'(err_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [6:0]    rs;
    logic [ND-1:0] rd;
    int            pick;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // 1: "15" with 6-cycle dwells
    show(2'b01, PAT[5], 6, 1'b1);
    show(2'b10, PAT[1], 6, 1'b1);
    show(2'b00, 7'd0, 4, 1'b1);
    check("t1_bcd", 32'(bcd_out), 32'h15);
    check("t1_err", 32'(err_out), 32'h0);

    // 2: dwells too short to capture
    for (int k = 0; k < 4; k++) begin
      show(2'b01, PAT[5], 3, 1'b1);
      show(2'b10, PAT[1], 3, 1'b1);
    end
    show(2'b00, 7'd0, 4, 1'b1);
    check("t2_no_frame", 32'(out_valid), 32'd0);

    // 3: blank digit0, illegal digit1
    show(2'b01, 7'b0000000, 6, 1'b1);
    show(2'b10, 7'b1010101, 6, 1'b1);
    show(2'b00, 7'd0, 4, 1'b1);
    check("t3_bcd", 32'(bcd_out), 32'hEF);
    check("t3_err", 32'(err_out), 32'h2);
`ifdef SEG7_ERR_CNT_EN
    check("t3_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // 4: consumer stalled, second frame dropped
    show(2'b10, PAT[4], 6, 1'b0);
    show(2'b01, PAT[2], 6, 1'b0);
    show(2'b10, PAT[7], 6, 1'b0);
    show(2'b01, PAT[3], 6, 1'b0);
    show(2'b00, 7'd0, 3, 1'b0);
    check("t4_bcd_held", 32'(bcd_out), 32'h42);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_valid_held", 32'(out_valid), 32'd1);
    step(7'd0, 2'b00, 1'b1);
    check("t4_valid_fell", 32'(out_valid), 32'd0);

    // 5: non-one-hot strobes never capture
    show(2'b11, PAT[8], 10, 1'b1);
    show(2'b00, PAT[8], 10, 1'b1);
    check("t5_no_frame", 32'(out_valid), 32'd0);

    // 6: reset discards a partial frame
    show(2'b01, PAT[5], 6, 1'b1);
    do_reset();
    show(2'b10, PAT[0], 6, 1'b1);
    show(2'b01, PAT[9], 6, 1'b1);
    show(2'b00, 7'd0, 4, 1'b1);
    check("t6_bcd", 32'(bcd_out), 32'h09);

    // randomized display traffic with random back-pressure
    for (int it = 0; it < 400; it++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4)      rd = 2'b01;
      else if (pick < 8) rd = 2'b10;
      else if (pick == 8) rd = 2'b11;
      else               rd = 2'b00;
      pick = $urandom_range(0, 11);
      if (pick < 10)      rs = PAT[pick];
      else if (pick == 10) rs = 7'd0;
      else                rs = 7'($urandom_range(0, 127));
      pick = $urandom_range(1, 8);
      for (int k = 0; k < pick; k++) step(rs, rd, 1'($urandom_range(0, 3) != 0));
    end
    show(2'b00, 7'd0, 4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
